// File: rtl/dram_cmd_scheduler_pkg.sv
// DRAM timing constants, command/op encodings and address-field positions
// shared by the command scheduler and its request FIFO.
package timing_parameters;

  localparam int unsigned tRCD   = 14;
  localparam int unsigned tCAS   = 14;
  localparam int unsigned tBURST = 4;
  localparam int unsigned tRAS   = 28;
  localparam int unsigned tRP    = 14;
  localparam int unsigned tWR    = 15;
  localparam int unsigned tCCD_S = 4;

  typedef enum logic [2:0] {
    ACT0 = 3'd0,
    ACT1 = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    WR0  = 3'd4,
    WR1  = 3'd5,
    PRE  = 3'd6
  } dram_cmd_e;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_IFETCH  = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  localparam int unsigned CH_BIT   = 6;
  localparam int unsigned BG_LSB   = 7;
  localparam int unsigned BG_MSB   = 9;
  localparam int unsigned BANK_LSB = 10;
  localparam int unsigned BANK_MSB = 11;
  localparam int unsigned COL_LSB  = 12;
  localparam int unsigned COL_MSB  = 17;
  localparam int unsigned ROW_LSB  = 18;
  localparam int unsigned ROW_MSB  = 33;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Closed-page precharge points, measured from ACT0.
  localparam int unsigned RD_PRE = max_u(tRAS, tRCD + tCAS + tBURST);
  localparam int unsigned WR_PRE = max_u(tRAS, tRCD + tCAS + tBURST + tWR);

endpackage

// File: rtl/dram_cmd_scheduler_fifo.sv
// In-order request FIFO; an entry pushed in one cycle is at the head the next.
module dram_req_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Closed-page DRAM command scheduler: one request at a time, ACT/CAS/PRE
// issued at fixed offsets from ACT0 using a saturating elapsed counter.
module dram_cmd_scheduler
  import timing_parameters::*;
#(
  parameter int QDEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [35:0] req_addr,
  output logic        cmd_valid,
  output dram_cmd_e   cmd_type,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [5:0]  cmd_col,
  output logic        q_full,
  output logic        q_empty,
  output logic        busy,
  output logic        req_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACT0, ST_ACT1, ST_CAS0, ST_CAS1, ST_PRE, ST_WAIT_RP
  } state_e;

  localparam logic [15:0] ACT1_AT   = 16'd2;
  localparam logic [15:0] CAS0_AT   = 16'(tRCD);
  localparam logic [15:0] CAS1_AT   = 16'(tRCD + 2);
  localparam logic [15:0] RD_PRE_AT = 16'(RD_PRE);
  localparam logic [15:0] WR_PRE_AT = 16'(WR_PRE);
  localparam logic [15:0] RP_LEN    = 16'(tRP);

  state_e      state, state_nxt;
  logic [15:0] cnt;
  logic [15:0] pre_at;
  logic        op_wr;
  logic [37:0] head;
  logic        push, pop, pop_c;
  logic        cmd_valid_c;
  dram_cmd_e   cmd_type_c;
  logic        unused_head;

  assign req_ready   = !q_full;
  assign push        = req_valid && req_ready && (req_op != OP_ILLEGAL);
  assign pop         = pop_c && !rst;
  assign busy        = (state != ST_IDLE);
  assign pre_at      = op_wr ? WR_PRE_AT : RD_PRE_AT;
  assign unused_head = ^{head[35:34], head[5:0]};

  dram_req_fifo #(
    .WIDTH (38),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({req_op, req_addr}),
    .pop     (pop),
    .rd_data (head),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_comb begin
    state_nxt   = state;
    cmd_valid_c = 1'b0;
    cmd_type_c  = ACT0;
    pop_c       = 1'b0;
    case (state)
      ST_IDLE: if (!q_empty) state_nxt = ST_ACT0;
      ST_ACT0: begin
        cmd_valid_c = 1'b1;
        cmd_type_c  = ACT0;
        state_nxt   = ST_ACT1;
      end
      ST_ACT1: if (cnt == ACT1_AT) begin
        cmd_valid_c = 1'b1;
        cmd_type_c  = ACT1;
        state_nxt   = ST_CAS0;
      end
      ST_CAS0: if (cnt == CAS0_AT) begin
        cmd_valid_c = 1'b1;
        cmd_type_c  = op_wr ? WR0 : RD0;
        state_nxt   = ST_CAS1;
      end
      ST_CAS1: if (cnt == CAS1_AT) begin
        cmd_valid_c = 1'b1;
        cmd_type_c  = op_wr ? WR1 : RD1;
        state_nxt   = ST_PRE;
      end
      ST_PRE: if (cnt == pre_at) begin
        cmd_valid_c = 1'b1;
        cmd_type_c  = PRE;
        pop_c       = 1'b1;
        state_nxt   = ST_WAIT_RP;
      end
      // Leaving straight for ACT0 keeps the next activate at PRE+tRP+1.
      ST_WAIT_RP: if (cnt == pre_at + RP_LEN) state_nxt = q_empty ? ST_IDLE : ST_ACT0;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gated by rst so an abort cannot leak a command in the reset cycle.
  assign cmd_valid = cmd_valid_c && !rst;
  assign cmd_type  = cmd_type_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      cmd_channel <= 1'b0;
      cmd_bg      <= '0;
      cmd_bank    <= '0;
      cmd_row     <= '0;
      cmd_col     <= '0;
      req_err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_err <= req_valid && req_ready && (req_op == OP_ILLEGAL);
      if (state_nxt == ST_ACT0) begin
        cnt         <= '0;
        op_wr       <= (head[37:36] == OP_WRITE);
        cmd_channel <= head[CH_BIT];
        cmd_bg      <= head[BG_MSB:BG_LSB];
        cmd_bank    <= head[BANK_MSB:BANK_LSB];
        cmd_row     <= head[ROW_MSB:ROW_LSB];
        cmd_col     <= head[COL_MSB:COL_LSB];
      end else if (cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Scenario bench for dram_cmd_scheduler: commands are logged by a monitor and
// compared against a timeline model derived from the closed-page timing rules.
module tb_dram_cmd_scheduler;
  import timing_parameters::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [35:0] req_addr = '0;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic        cmd_channel;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [5:0]  cmd_col;
  logic        q_full, q_empty, busy, req_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_pre = -1000;

  typedef struct packed {
    logic [31:0] t;
    logic [2:0]  ty;
    logic        ch;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [5:0]  col;
  } cmd_rec_t;

  cmd_rec_t log_q[$];
  cmd_rec_t exp_q[$];

  dram_cmd_scheduler #(.QDEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .cmd_valid   (cmd_valid),
    .cmd_type    (cmd_type),
    .cmd_channel (cmd_channel),
    .cmd_bg      (cmd_bg),
    .cmd_bank    (cmd_bank),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col),
    .q_full      (q_full),
    .q_empty     (q_empty),
    .busy        (busy),
    .req_err     (req_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_act(logic [2:0] ty);
    return (ty == 3'd0) || (ty == 3'd1);
  endfunction

  function automatic bit is_cas(logic [2:0] ty);
    return (ty >= 3'd2) && (ty <= 3'd5);
  endfunction

  // Row only meaningful on ACT, column only on RD/WR; mask the rest.
  always @(negedge clk) begin
    if (cmd_valid) begin
      cmd_rec_t r;
      r.t    = cyc;
      r.ty   = cmd_type;
      r.ch   = cmd_channel;
      r.bg   = cmd_bg;
      r.bank = cmd_bank;
      r.row  = is_act(cmd_type) ? cmd_row : 16'd0;
      r.col  = is_cas(cmd_type) ? cmd_col : 6'd0;
      log_q.push_back(r);
    end
  end

  function automatic cmd_rec_t mk(int t, logic [2:0] ty, logic [35:0] a);
    cmd_rec_t r;
    r.t    = t;
    r.ty   = ty;
    r.ch   = a[6];
    r.bg   = a[9:7];
    r.bank = a[11:10];
    r.row  = is_act(ty) ? a[33:18] : 16'd0;
    r.col  = is_cas(ty) ? a[17:12] : 6'd0;
    return r;
  endfunction

  // Timeline model: each legal request starts two cycles after acceptance or
  // tRP+1 after the previous precharge, whichever is later.
  task automatic model_req(input int acc, input logic [1:0] op, input logic [35:0] a);
    int t0, pre, data_end;
    bit wr;
    if (op == 2'd3) return;
    wr = (op == 2'd1);
    t0 = acc + 2;
    if (last_pre + int'(tRP) + 1 > t0) t0 = last_pre + int'(tRP) + 1;
    data_end = int'(tRCD + tCAS + tBURST) + (wr ? int'(tWR) : 0);
    pre = (int'(tRAS) > data_end) ? int'(tRAS) : data_end;
    exp_q.push_back(mk(t0, 3'd0, a));
    exp_q.push_back(mk(t0 + 2, 3'd1, a));
    exp_q.push_back(mk(t0 + int'(tRCD), wr ? 3'd4 : 3'd2, a));
    exp_q.push_back(mk(t0 + int'(tRCD) + 2, wr ? 3'd5 : 3'd3, a));
    exp_q.push_back(mk(t0 + pre, 3'd6, a));
    last_pre = t0 + pre;
  endtask

  task automatic send(input logic [1:0] op, input logic [35:0] a, output int acc);
    int n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    acc = cyc;
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: req_ready=%0b, required 1 within 3000 cycles", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || !q_empty || log_q.size() < exp_q.size()) && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: busy=%0b q_empty=%0b, required idle within 5000 cycles", busy, q_empty);
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (q_empty !== 1'b1)   begin n_fail++; $display("FAIL rst_q_empty: got %b, required 1", q_empty); end
    n_checks++; if (q_full !== 1'b0)    begin n_fail++; $display("FAIL rst_q_full: got %b, required 0", q_full); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b, required 1", req_ready); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_valid: got %b, required 0", cmd_valid); end
    n_checks++; if (req_err !== 1'b0)   begin n_fail++; $display("FAIL rst_req_err: got %b, required 0", req_err); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_checks++;
    if ({cmd_type, cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col} !== '0) begin
      n_fail++;
      $display("FAIL rst_cmd_fields: got %h, required 0",
               {cmd_type, cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    log_q.delete();
  endtask

  task automatic test_single(input logic [1:0] op, input string name);
    int acc;
    send(op, 36'h012345678, acc);
    model_req(acc, op, 36'h012345678);
    wait_idle();
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d commands, required %0d", name, log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_cmd%0d: got %h, required %h", name, i,
                 (i < log_q.size()) ? log_q[i] : '0, exp_q[i]);
      end
    end
    log_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int a0, a1;
    int second_act;
    send(2'd0, 36'h0_1234_5678, a0);
    send(2'd2, 36'h3_8765_43C0, a1);
    model_req(a0, 2'd0, 36'h0_1234_5678);
    model_req(a1, 2'd2, 36'h3_8765_43C0);
    wait_idle();
    second_act = (log_q.size() > 5) ? int'(log_q[5].t) : -1;
    n_checks++;
    if (log_q.size() < 6 || second_act != int'(exp_q[4].t) + int'(tRP) + 1) begin
      n_fail++; $display("FAIL b2b_act_gap: got ACT0 at %0d, required %0d", second_act, int'(exp_q[4].t) + int'(tRP) + 1);
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_cmd%0d: got %h, required %h", i, (i < log_q.size()) ? log_q[i] : '0, exp_q[i]);
      end
    end
    n_checks++;
    if (q_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_q_empty: got %b, required 1", q_empty); end
    log_q.delete(); exp_q.delete();
  endtask

  task automatic test_full();
    int acc;
    int first_pre;
    logic [35:0] a;
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      send(2'(i % 3), a, acc);
      model_req(acc, 2'(i % 3), a);
    end
    first_pre = int'(exp_q[4].t);
    @(negedge clk);
    n_checks++; if (q_full !== 1'b1)    begin n_fail++; $display("FAIL full_q_full: got %b, required 1", q_full); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_req_ready: got %b, required 0", req_ready); end
    @(posedge clk);
    #1;
    a = 36'h9_ABCD_E123;
    send(2'd1, a, acc);
    n_checks++;
    if (acc != first_pre + 1) begin
      n_fail++; $display("FAIL full_17th_accept: got cycle %0d, required %0d", acc, first_pre + 1);
    end
    model_req(acc, 2'd1, a);
    wait_idle();
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL full_count: got %0d commands, required %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_cmd%0d: got %h, required %h", i, (i < log_q.size()) ? log_q[i] : '0, exp_q[i]);
      end
    end
    log_q.delete(); exp_q.delete();
  endtask

  task automatic test_illegal();
    int acc, start;
    start = cyc;
    send(2'd3, 36'h0_1234_5678, acc);
    n_checks++;
    if (acc != start) begin n_fail++; $display("FAIL ill_accept: got cycle %0d, required %0d", acc, start); end
    @(negedge clk);
    n_checks++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL ill_err_pulse: got %b, required 1", req_err); end
    @(negedge clk);
    n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL ill_err_width: got %b, required 0", req_err); end
    repeat (20) @(negedge clk);
    n_checks++; if (log_q.size() != 0) begin n_fail++; $display("FAIL ill_no_cmd: got %0d commands, required 0", log_q.size()); end
    n_checks++; if (q_empty !== 1'b1)  begin n_fail++; $display("FAIL ill_q_empty: got %b, required 1", q_empty); end
    @(posedge clk);
    #1;
    log_q.delete();
  endtask

  task automatic test_reset_mid();
    int acc, target;
    send(2'd0, 36'h0_1234_5678, acc);
    model_req(acc, 2'd0, 36'h0_1234_5678);
    target = acc + 2 + int'(tRCD) + 1;
    while (cyc < target) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_cmd_valid: got %b, required 0", cmd_valid); end
    @(negedge clk);
    n_checks++;
    if ({busy, q_full, req_err, cmd_valid} !== 4'b0 || q_empty !== 1'b1 || req_ready !== 1'b1 ||
        {cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col} !== '0) begin
      n_fail++;
      $display("FAIL rmid_reset_vals: got busy=%b full=%b err=%b valid=%b empty=%b ready=%b fields=%h, required 0 0 0 0 1 1 0",
               busy, q_full, req_err, cmd_valid, q_empty, req_ready, {cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(negedge clk);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    n_checks++;
    if (log_q.size() != 3) begin n_fail++; $display("FAIL rmid_no_pre: got %0d commands, required 3", log_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rmid_cmd%0d: got %h, required %h", i, (i < log_q.size()) ? log_q[i] : '0, exp_q[i]);
      end
    end
    log_q.delete(); exp_q.delete();
    last_pre = -1000;
    @(posedge clk);
    #1;
    send(2'd1, 36'h5_0F0F_0F0F, acc);
    model_req(acc, 2'd1, 36'h5_0F0F_0F0F);
    wait_idle();
    n_checks++;
    if (log_q.size() == 0 || log_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL rmid_restart_act0: got %h, required %h", (log_q.size() > 0) ? log_q[0] : '0, exp_q[0]);
    end
    n_checks++;
    if (log_q.size() != 5) begin n_fail++; $display("FAIL rmid_restart_count: got %0d, required 5", log_q.size()); end
    log_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int acc;
    logic [1:0]  op;
    logic [35:0] a;
    for (int i = 0; i < 25; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      send(op, a, acc);
      model_req(acc, op, a);
      repeat ($urandom_range(0, 50)) @(posedge clk);
      #1;
    end
    wait_idle();
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d commands, required %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_cmd%0d: got %h, required %h", i, (i < log_q.size()) ? log_q[i] : '0, exp_q[i]);
      end
    end
    log_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    repeat (8) @(posedge clk);
    #1;
    test_single(2'd0, "single_read");
    test_single(2'd1, "single_write");
    test_back_to_back();
    test_illegal();
    test_full();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_cmd_scheduler.md
DRAM_CMD_SCHEDULER -- requirements
Module: dram_cmd_scheduler

Interface
REQ-001 SHALL have parameter QDEPTH, default 16, meaning request queue depth in entries.
REQ-002 SHALL have port clk  input  1  single clock; all timing is counted in clk cycles.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request offered.
REQ-005 SHALL have port req_ready  output  1  equals !q_full; a request is accepted when req_valid && req_ready.
REQ-006 SHALL have port req_op  input  2  0=data read, 1=write, 2=instruction fetch (treated as read), 3=illegal.
REQ-007 SHALL have port req_addr  input  36  physical address.
REQ-008 SHALL have port cmd_valid  output  1  one-cycle strobe, asserted once per issued command.
REQ-009 SHALL have port cmd_type  output  3  dram_cmd_e: ACT0, ACT1, RD0, RD1, WR0, WR1, PRE.
REQ-010 SHALL have ports cmd_channel (1), cmd_bg (3), cmd_bank (2), cmd_row (16), cmd_col (6), all output, decoded fields of the head request.
REQ-011 SHALL have ports q_full, q_empty, busy (output, 1 each) and req_err (output, 1, one-cycle pulse on an illegal op).

Function
REQ-012 Address decode SHALL be: channel=addr[6], bg=addr[9:7], bank=addr[11:10], col=addr[17:12], row=addr[33:18].
REQ-013 Accepted requests SHALL be stored as {op,addr} (38 bits) in an in-order FIFO; an entry pushed in cycle N is visible at the head in cycle N+1.
REQ-014 A push while q_full SHALL be refused (req_ready=0) with no state change; push and pop in the same cycle SHALL both take effect.
REQ-015 op==3 SHALL not be enqueued, SHALL pulse req_err for one cycle, and SHALL still be consumed (req_ready unaffected).
REQ-016 The FSM SHALL have states IDLE, ACT0, ACT1, CAS0, CAS1, PRE, WAIT_RP, and SHALL use closed-page, one-request-at-a-time policy.
REQ-017 IDLE->ACT0 SHALL occur when !q_empty; ACT0 SHALL be issued in the cycle after the transition, and that cycle is T0. The elapsed counter SHALL be cleared at T0.
REQ-018 Issue times SHALL be: ACT1 at T0+2; RD0/WR0 at T0+tRCD; RD1/WR1 at T0+tRCD+2.
REQ-019 For a read, PRE SHALL be issued at T0+max(tRAS, tRCD+tCAS+tBURST).
REQ-020 For a write, PRE SHALL be issued at T0+max(tRAS, tRCD+tCAS+tBURST+tWR).
REQ-021 The FIFO head SHALL be popped in the PRE cycle; WAIT_RP SHALL hold for tRP cycles after PRE and then go to IDLE, with next ACT0 no earlier than PRE+tRP+1.
REQ-022 Command fields SHALL be held stable from ACT0 to PRE inclusive; cmd_row SHALL be valid on ACT, cmd_col on RD/WR, and both SHALL be don't-care on PRE.
REQ-023 The elapsed counter SHALL be 16 bits and saturating; all comparisons SHALL be unsigned, with max() computed from package constants at elaboration.
REQ-024 busy SHALL be 1 in every state except IDLE.

Reset
REQ-025 On rst: FIFO flushed, q_empty=1, q_full=0, req_ready=1, cmd_valid=0, req_err=0, busy=0, state=IDLE, counter=0, cmd_* fields=0.
REQ-026 rst asserted mid-sequence SHALL abort it with no further commands issued (including a pending PRE); the first command after release SHALL be ACT0 of a newly accepted request.

Structure
REQ-027 tRCD, tCAS, tBURST, tRAS, tRP, tWR, tCCD_S, dram_cmd_e, the op-code localparams and the address-field bit positions SHALL live in package timing_parameters.
REQ-028 The FIFO SHALL be a separate sub-module dram_req_fifo (parameters WIDTH=38, DEPTH=QDEPTH); the FSM and decode SHALL stay in dram_cmd_scheduler.

Verification
REQ-029 Single read: op=0, addr=36'h012345678 accepted at cycle 10 -> ACT0 at cycle 12 with ch=1, bg=4, bank=1, row=1165; ACT1 at 14; RD0 at 12+tRCD with col=5; RD1 at 14+tRCD; PRE at 12+max(tRAS, tRCD+tCAS+tBURST).
REQ-030 Single write, same address with op=1 -> WR0/WR1 in place of RD0/RD1; PRE at T0+max(tRAS, tRCD+tCAS+tBURST+tWR).
REQ-031 Back-to-back reads with ops 0 then 2 -> second ACT0 exactly at first PRE+tRP+1; commands issued in order; q_empty=1 after the second PRE.
REQ-032 Push 17 requests while the scheduler is stalled -> q_full=1 after 16; the 17th is held with req_ready=0; it is accepted in the cycle after the first pop.
REQ-033 op=3 offered -> req_err pulses for 1 cycle, no command is issued, q_empty stays 1.
REQ-034 rst raised at T0+tRCD+1 mid-read -> no PRE issued, all outputs at reset values, and the next request produces ACT0 two cycles after acceptance.
